// File: rtl/sweep_nco_pkg.sv
// Shared types and constants for the sweeping NCO.
// Latency: n/a (package only).
// Backpressure: n/a.
package sweep_nco_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  // wave_sel codes
  localparam logic [1:0] WAVE_SAW = 2'd0;
  localparam logic [1:0] WAVE_TRI = 2'd1;
  localparam logic [1:0] WAVE_SQR = 2'd2;
  localparam logic [1:0] WAVE_DC  = 2'd3;

  // mode codes; code 3 is treated as repeat
  localparam logic [1:0] MODE_ONCE   = 2'd0;
  localparam logic [1:0] MODE_REPEAT = 2'd1;
  localparam logic [1:0] MODE_UPDOWN = 2'd2;
  localparam logic [1:0] MODE_ALT    = 2'd3;

  // Dither LFSR: Fibonacci, taps 16,14,13,11 expressed as a feedback mask
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Half-rail code for a sample of the given width
  function automatic logic [63:0] midscale(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sweep_nco_wave.sv
// Phase-to-sample shaper (saw/triangle/square/DC) with optional LFSR dither.
// Latency: combinational sample; dither LFSR advances one step per accepted sample.
// Backpressure: none; optional dither enabled by defining SWEEP_NCO_DITHER_EN.
module sweep_nco_wave
  import sweep_nco_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic [WIDTH-1:0] p,
  input  logic [1:0]       wave_sel,
  output logic [WIDTH-1:0] sample
);

  localparam logic [WIDTH-1:0] MID = WIDTH'(midscale(WIDTH));

  logic [WIDTH-1:0] tri_val;
  logic [WIDTH-1:0] shaped;

  // Map the top phase bits onto the selected waveform
  always_comb begin
    tri_val = {p[WIDTH-2:0], 1'b0};
    case (wave_sel)
      WAVE_SAW: shaped = p;
      WAVE_TRI: shaped = p[WIDTH-1] ? ~tri_val : tri_val;
      WAVE_SQR: shaped = {WIDTH{p[WIDTH-1]}};
      default:  shaped = MID;
    endcase
  end

`ifdef SWEEP_NCO_DITHER_EN
  logic [15:0] lfsr;

  // Advance the dither sequence only when a sample is actually produced
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  // Add one LSB of dither, saturating so full scale never wraps to zero
  always_comb begin
    if (shaped == {WIDTH{1'b1}}) begin
      sample = shaped;
    end else begin
      sample = shaped + WIDTH'(lfsr[0]);
    end
  end
`else
  logic unused_dither_ports;
  assign unused_dither_ports = ^{clk, rst_n, advance};
  assign sample = shaped;
`endif

endmodule

// File: rtl/sweep_nco.sv
// Linearly swept NCO feeding the delta-sigma DAC; parks at mid-scale when idle.
// Latency: dout registered 1 cycle after each sample_en in UP/DOWN.
// Backpressure: none; sample_en paces output, stop wins over start. Dither: SWEEP_NCO_DITHER_EN.
module sweep_nco
  import sweep_nco_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int PHASE_W   = 24,
  parameter int SWEEP_DIV = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_en,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         wave_sel,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] f_start,
  input  logic [PHASE_W-1:0] f_stop,
  input  logic [PHASE_W-1:0] f_step,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid,
  output logic               busy,
  output logic               done
);

  localparam logic [WIDTH-1:0] MID = WIDTH'(midscale(WIDTH));
  localparam int DIV_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SWEEP_DIV - 1);

  state_t             state;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] freq;
  logic [DIV_W-1:0]   div;

  // Configuration captured at start so mid-sweep input changes are harmless
  logic [PHASE_W-1:0] cfg_start;
  logic [PHASE_W-1:0] cfg_stop;
  logic [PHASE_W-1:0] cfg_step;
  logic [1:0]         cfg_mode;
  logic [1:0]         cfg_wave;

  logic               active;
  logic               advance;
  logic [PHASE_W-1:0] phase_nxt;
  logic [PHASE_W:0]   freq_up;
  logic [PHASE_W:0]   freq_dn;
  logic               up_in_range;
  logic               dn_in_range;
  logic [WIDTH-1:0]   sample;

  // Next phase and candidate frequencies, with one guard bit for carry/borrow
  always_comb begin
    active      = (state != ST_IDLE);
    advance     = active && sample_en && !stop;
    phase_nxt   = phase + freq;
    freq_up     = {1'b0, freq} + {1'b0, cfg_step};
    freq_dn     = {1'b0, freq} - {1'b0, cfg_step};
    up_in_range = (freq_up < {1'b0, cfg_stop});
    dn_in_range = !freq_dn[PHASE_W] && (freq_dn[PHASE_W-1:0] > cfg_start);
  end

  sweep_nco_wave #(
    .WIDTH(WIDTH)
  ) u_wave (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (advance),
    .p        (phase_nxt[PHASE_W-1 -: WIDTH]),
    .wave_sel (cfg_wave),
    .sample   (sample)
  );

  // Sweep FSM, phase accumulator, step divider and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase      <= '0;
      freq       <= '0;
      div        <= '0;
      cfg_start  <= '0;
      cfg_stop   <= '0;
      cfg_step   <= '0;
      cfg_mode   <= MODE_ONCE;
      cfg_wave   <= WAVE_SAW;
      dout       <= MID;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      done       <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        dout  <= MID;
      end else begin
        case (state)
          ST_IDLE: begin
            dout <= MID;
            if (start) begin
              cfg_start <= f_start;
              cfg_stop  <= f_stop;
              cfg_step  <= f_step;
              cfg_mode  <= mode;
              cfg_wave  <= wave_sel;
              phase     <= '0;
              div       <= '0;
              freq      <= f_start;
              state     <= ST_UP;
              busy      <= 1'b1;
            end
          end
          ST_UP, ST_DOWN: begin
            if (sample_en) begin
              phase      <= phase_nxt;
              dout       <= sample;
              dout_valid <= 1'b1;
              if (div != DIV_LAST) begin
                div <= div + 1'b1;
              end else begin
                div <= '0;
                if (state == ST_UP) begin
                  if (up_in_range) begin
                    freq <= freq_up[PHASE_W-1:0];
                  end else begin
                    freq <= cfg_stop;
                    case (cfg_mode)
                      MODE_ONCE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        dout  <= MID;
                      end
                      MODE_UPDOWN: state <= ST_DOWN;
                      default:     freq  <= cfg_start;
                    endcase
                  end
                end else begin
                  if (dn_in_range) begin
                    freq <= freq_dn[PHASE_W-1:0];
                  end else begin
                    freq  <= cfg_start;
                    state <= ST_UP;
                  end
                end
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            dout  <= MID;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sweep_nco.sv
// Self-checking bench for sweep_nco: directed scenarios plus randomized sweeps.
// Latency: outputs compared 1 ns after each rising edge against a sample-count model.
// Backpressure: none; sample_en pattern driven by the bench.
module tb_sweep_nco;

  localparam int WIDTH     = 16;
  localparam int PHASE_W   = 24;
  localparam int SWEEP_DIV = 4;
  localparam longint PMASK = (64'd1 << PHASE_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sample_en;
  logic               start;
  logic               stop;
  logic [1:0]         wave_sel;
  logic [1:0]         mode;
  logic [PHASE_W-1:0] f_start;
  logic [PHASE_W-1:0] f_stop;
  logic [PHASE_W-1:0] f_step;
  logic [WIDTH-1:0]   dout;
  logic               dout_valid;
  logic               busy;
  logic               done;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit          m_active;
  bit          m_up;
  longint      m_phase;
  longint      m_freq;
  longint      m_fs;
  longint      m_fe;
  longint      m_fstep;
  int          m_mode;
  int          m_wave;
  int          m_count;
  logic [15:0] m_dout;
  bit          m_valid;
  bit          m_done;

  always #5 clk = ~clk;

  sweep_nco #(
    .WIDTH(WIDTH),
    .PHASE_W(PHASE_W),
    .SWEEP_DIV(SWEEP_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .start      (start),
    .stop       (stop),
    .wave_sel   (wave_sel),
    .mode       (mode),
    .f_start    (f_start),
    .f_stop     (f_stop),
    .f_step     (f_step),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [15:0] shape(input longint ph, input int wave);
    longint p;
    p = ph >> (PHASE_W - WIDTH);
    case (wave)
      0:       return 16'(p);
      1:       return (p < 32768) ? 16'(2 * p) : 16'(65535 - 2 * (p - 32768));
      2:       return (p >= 32768) ? 16'hFFFF : 16'h0000;
      default: return 16'h8000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the reference by one clock given the inputs present before the edge
  task automatic model_step(input bit se, input bit st, input bit sp);
    m_valid = 1'b0;
    m_done  = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0; m_up = 1'b1; m_phase = 0; m_freq = 0; m_count = 0;
      m_dout = 16'h8000;
    end else if (sp) begin
      m_active = 1'b0;
      m_dout   = 16'h8000;
    end else if (!m_active) begin
      m_dout = 16'h8000;
      if (st) begin
        m_fs = f_start; m_fe = f_stop; m_fstep = f_step;
        m_mode = mode; m_wave = wave_sel;
        m_phase = 0; m_count = 0; m_freq = m_fs; m_up = 1'b1; m_active = 1'b1;
      end
    end else if (se) begin
      m_phase = (m_phase + m_freq) & PMASK;
      m_count++;
      m_valid = 1'b1;
      m_dout  = shape(m_phase, m_wave);
      if (m_count % SWEEP_DIV == 0) begin
        if (m_up) begin
          if (m_freq + m_fstep < m_fe) m_freq = m_freq + m_fstep;
          else begin
            m_freq = m_fe;
            if (m_mode == 0) begin
              m_active = 1'b0; m_done = 1'b1; m_dout = 16'h8000;
            end else if (m_mode == 2) m_up = 1'b0;
            else m_freq = m_fs;
          end
        end else begin
          if (m_freq >= m_fstep && m_freq - m_fstep > m_fs) m_freq = m_freq - m_fstep;
          else begin
            m_freq = m_fs;
            m_up   = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick(input bit se, input bit st, input bit sp);
    sample_en = se; start = st; stop = sp;
    model_step(se, st, sp);
    @(posedge clk);
    #1;
    check("dout", 32'(dout), 32'(m_dout));
    check("dout_valid", 32'(dout_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done));
    check("freq", 32'(dut.freq), 32'(m_freq));
    sample_en = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic cfg(input logic [23:0] fs, input logic [23:0] fe, input logic [23:0] fst,
                     input logic [1:0] md, input logic [1:0] wv);
    f_start = fs; f_stop = fe; f_step = fst; mode = md; wave_sel = wv;
  endtask

  initial begin
    int vcount;
    rst_n = 1'b0; sample_en = 1'b0; start = 1'b0; stop = 1'b0;
    cfg(24'h0, 24'h0, 24'h0, 2'd0, 2'd0);
    m_active = 1'b0; m_up = 1'b1; m_phase = 0; m_freq = 0; m_count = 0;
    m_fs = 0; m_fe = 0; m_fstep = 0; m_mode = 0; m_wave = 0; m_dout = 16'h8000;
    repeat (3) tick(0, 0, 0);
    check("reset_dout", 32'(dout), 32'h8000);
    check("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick(0, 0, 0);

    // Saw, repeat, constant frequency: 256 samples make one full wrap
    cfg(24'h010000, 24'h010000, 24'h0, 2'd1, 2'd0);
    tick(1, 1, 0);
    check("busy_after_start", 32'(busy), 32'h1);
    check("no_valid_on_start", 32'(dout_valid), 32'h0);
    for (int i = 1; i <= 256; i++) begin
      tick(1, 0, 0);
      if (i == 1)   check("saw_first", 32'(dout), 32'h0100);
      if (i == 2)   check("saw_second", 32'(dout), 32'h0200);
      if (i == 256) check("saw_wrap", 32'(dout), 32'h0000);
    end
    tick(0, 0, 1);

    // Triangle at quarter and three-quarter phase
    cfg(24'h400000, 24'h400000, 24'h0, 2'd1, 2'd1);
    tick(0, 1, 0);
    tick(1, 0, 0);
    check("tri_quarter", 32'(dout), 32'h8000);
    tick(1, 0, 0);
    tick(1, 0, 0);
    check("tri_three_quarter", 32'(dout), 32'h7FFF);
    tick(0, 0, 1);

    // Square at three-quarter phase
    cfg(24'h400000, 24'h400000, 24'h0, 2'd1, 2'd2);
    tick(0, 1, 0);
    repeat (3) tick(1, 0, 0);
    check("sqr_three_quarter", 32'(dout), 32'hFFFF);
    tick(0, 0, 1);

    // Once mode: steps every 4 samples, ends on the 16th
    cfg(24'h1000, 24'h1400, 24'h100, 2'd0, 2'd0);
    tick(0, 1, 0);
    for (int i = 1; i <= 16; i++) begin
      tick(0, 0, 0);
      tick(1, 0, 0);
      if (i == 4)  check("once_freq_step1", 32'(dut.freq), 32'h1100);
      if (i == 15) check("once_busy_before_end", 32'(busy), 32'h1);
      if (i == 16) begin
        check("once_done", 32'(done), 32'h1);
        check("once_busy_end", 32'(busy), 32'h0);
        check("once_dout_mid", 32'(dout), 32'h8000);
      end
    end
    tick(0, 0, 0);
    check("once_done_single", 32'(done), 32'h0);

    // Up/down mode: climbs to f_stop, falls back to f_start, climbs again
    cfg(24'h1000, 24'h1400, 24'h100, 2'd2, 2'd1);
    tick(0, 1, 0);
    for (int i = 1; i <= 48; i++) begin
      tick(1, 0, 0);
      if (i == 16) check("ud_top", 32'(dut.freq), 32'h1400);
      if (i == 20) check("ud_fall", 32'(dut.freq), 32'h1300);
      if (i == 32) check("ud_bottom", 32'(dut.freq), 32'h1000);
      if (i == 36) check("ud_rise", 32'(dut.freq), 32'h1100);
    end

    // Stop at sample 7 of a fresh sweep
    tick(0, 0, 1);
    tick(0, 1, 0);
    repeat (6) tick(1, 0, 0);
    tick(1, 0, 1);
    check("stop_busy", 32'(busy), 32'h0);
    check("stop_no_done", 32'(done), 32'h0);

    // Start and stop together: stop wins
    tick(0, 1, 1);
    check("start_stop_idle", 32'(busy), 32'h0);
    tick(1, 0, 0);

    // Start while busy does not reload the configuration
    cfg(24'h2000, 24'h3000, 24'h200, 2'd1, 2'd0);
    tick(0, 1, 0);
    repeat (5) tick(1, 0, 0);
    cfg(24'h100000, 24'h200000, 24'h1000, 2'd0, 2'd2);
    tick(1, 1, 0);
    repeat (5) tick(1, 0, 0);
    check("busy_start_ignored", 32'(dut.freq), 32'h2400);

    // Reset mid-sweep, then no valid pulses until a new start
    rst_n = 1'b0;
    tick(1, 0, 0);
    tick(1, 0, 0);
    check("rst_mid_dout", 32'(dout), 32'h8000);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_valid", 32'(dout_valid), 32'h0);
    check("rst_mid_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 0);
      vcount += int'(dout_valid);
    end
    check("rst_no_valid_pulses", 32'(vcount), 32'h0);

    // Randomized sweeps, including degenerate and mid-sweep start/stop
    for (int it = 0; it < 8; it++) begin
      cfg(24'($urandom_range(0, 24'h3FFFFF)), 24'($urandom_range(0, 24'h7FFFFF)),
          24'($urandom_range(0, 24'h40000)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      if (it == 3) f_step = 24'h0;
      tick(0, 1, 0);
      for (int c = 0; c < 300; c++) begin
        bit se, st, sp;
        se = ($urandom_range(0, 3) != 0);
        st = ($urandom_range(0, 39) == 0);
        sp = ($urandom_range(0, 149) == 0);
        if (st) begin
          f_start = 24'($urandom);
          f_stop  = 24'($urandom);
          f_step  = 24'($urandom_range(0, 24'h80000));
          mode    = 2'($urandom_range(0, 3));
          wave_sel = 2'($urandom_range(0, 3));
        end
        tick(se, st, sp);
      end
      tick(0, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
